// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: credit-based instruction requests, in-order prefetch FIFO and IF/ID register.
// Defining FETCH_PERF_CNT_EN builds the saturating bubble_cnt/drop_cnt performance counters.
module fetch_prefetch_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned     FIFO_DEPTH = 4,
   parameter logic [31:0]     NOP_INSTR  = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            StallD,
   input  logic            FlushD,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic [31:0]     InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD,
   output logic [31:0]     bubble_cnt,
   output logic [31:0]     drop_cnt
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = 16;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   out_q, out_d, cnt_q, cnt_d;
   logic [DW-1:0]   disc_q, disc_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   st_wr_q, st_wr_d, st_rd_q, st_rd_d;
   logic [XLEN-1:0] fifo_pc_q [FIFO_DEPTH];
   logic [XLEN-1:0] fifo_pc_d [FIFO_DEPTH];
   logic [31:0]     fifo_data_q [FIFO_DEPTH];
   logic [31:0]     fifo_data_d [FIFO_DEPTH];
   logic [XLEN-1:0] st_pc_q [FIFO_DEPTH];
   logic [XLEN-1:0] st_pc_d [FIFO_DEPTH];
   logic [31:0]     instrd_q, instrd_d;
   logic [XLEN-1:0] pcd_q, pcd_d, pcplus4d_q, pcplus4d_d;
   logic            validd_q, validd_d;

   logic [CW:0] credit_sum;
   logic        req_fire, rsp_drop, push, pop, fifo_empty;

   assign credit_sum     = {1'b0, out_q} + {1'b0, cnt_q};
   assign imem_req_valid = (credit_sum < DEPTH_C) & ~PCSrcE;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid & imem_req_ready;
   // a response landing in the redirect cycle belongs to the old stream
   assign rsp_drop       = imem_rsp_valid & ((disc_q != '0) | PCSrcE);
   assign push           = imem_rsp_valid & ~rsp_drop;
   assign fifo_empty     = (cnt_q == '0);
   assign pop            = ~FlushD & ~StallD & ~PCSrcE & ~fifo_empty;

   always_comb begin
      pc_d        = pc_q;
      out_d       = out_q;
      disc_d      = disc_q;
      cnt_d       = cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      st_wr_d     = st_wr_q;
      st_rd_d     = st_rd_q;
      fifo_pc_d   = fifo_pc_q;
      fifo_data_d = fifo_data_q;
      st_pc_d     = st_pc_q;
      if (PCSrcE) begin
         pc_d     = PCTargetE;
         out_d    = '0;
         disc_d   = disc_q + DW'(out_q) - DW'(imem_rsp_valid);
         cnt_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         st_wr_d  = '0;
         st_rd_d  = '0;
      end else begin
         if (req_fire) begin
            pc_d             = pc_q + XLEN'(4);
            st_pc_d[st_wr_q] = pc_q;
            st_wr_d          = st_wr_q + AW'(1);
         end
         if (rsp_drop) disc_d = disc_q - DW'(1);
         if (push) begin
            fifo_pc_d[wr_ptr_q]   = st_pc_q[st_rd_q];
            fifo_data_d[wr_ptr_q] = imem_rsp_data;
            wr_ptr_d              = wr_ptr_q + AW'(1);
            st_rd_d               = st_rd_q + AW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         out_d = out_q + CW'(req_fire) - CW'(push);
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      instrd_d   = NOP_INSTR;
      pcd_d      = '0;
      pcplus4d_d = '0;
      validd_d   = 1'b0;
      if (!FlushD && StallD) begin
         instrd_d   = instrd_q;
         pcd_d      = pcd_q;
         pcplus4d_d = pcplus4d_q;
         validd_d   = validd_q;
      end else if (pop) begin
         instrd_d   = fifo_data_q[rd_ptr_q];
         pcd_d      = fifo_pc_q[rd_ptr_q];
         pcplus4d_d = fifo_pc_q[rd_ptr_q] + XLEN'(4);
         validd_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         out_q       <= '0;
         disc_q      <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         st_wr_q     <= '0;
         st_rd_q     <= '0;
         fifo_pc_q   <= '{default: '0};
         fifo_data_q <= '{default: '0};
         st_pc_q     <= '{default: '0};
         instrd_q    <= NOP_INSTR;
         pcd_q       <= '0;
         pcplus4d_q  <= '0;
         validd_q    <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         out_q       <= out_d;
         disc_q      <= disc_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         st_wr_q     <= st_wr_d;
         st_rd_q     <= st_rd_d;
         fifo_pc_q   <= fifo_pc_d;
         fifo_data_q <= fifo_data_d;
         st_pc_q     <= st_pc_d;
         instrd_q    <= instrd_d;
         pcd_q       <= pcd_d;
         pcplus4d_q  <= pcplus4d_d;
         validd_q    <= validd_d;
      end
   end

   assign InstrD   = instrd_q;
   assign PCD      = pcd_q;
   assign PCPlus4D = pcplus4d_q;
   assign ValidD   = validd_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d, drop_cnt_q, drop_cnt_d;
   logic        bubble_inc;

   // only bubbles caused by an empty buffer count, not flushes or redirects
   assign bubble_inc = ~FlushD & ~StallD & ~PCSrcE & fifo_empty;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      if (bubble_inc && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 32'd1;
      if (rsp_drop && (drop_cnt_q != '1))     drop_cnt_d   = drop_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bubble_cnt_q <= '0;
         drop_cnt_q   <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign drop_cnt   = drop_cnt_q;
`else
   assign bubble_cnt = '0;
   assign drop_cnt   = '0;
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: echo memory with configurable latency and a PC scoreboard.
module tb_fetch_prefetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        StallD, FlushD;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;
   logic [31:0] bubble_cnt, drop_cnt;

`ifdef FETCH_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   int total = 0;
   int bad = 0;
   int lat = 1;
   int cyc_n = 0;
   int acc_cnt = 0;
   int load_cnt = 0;
   int lc;
   logic was_load = 1'b0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] a;
      int          due;
   } mreq_t;
   mreq_t mq[$];

   fetch_prefetch_unit dut (
      .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
      .StallD(StallD), .FlushD(FlushD),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
      .bubble_cnt(bubble_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic load_exp(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
   endtask

   // echo memory: returns the request address as the instruction word after lat cycles
   always @(posedge clk) begin
      if (!rst) begin
         mq.delete();
         acc_cnt = 0;
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
      end else begin
         cyc_n++;
         if (imem_req_valid && imem_req_ready) begin
            mq.push_back('{imem_req_addr, cyc_n + lat - 1});
            acc_cnt++;
         end
         if (mq.size() > 0 && mq[0].due <= cyc_n) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mq[0].a;
            void'(mq.pop_front());
         end else begin
            imem_rsp_valid <= 1'b0;
         end
      end
   end

   always @(posedge clk) was_load <= rst && !StallD && !FlushD;

   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst) begin
         load_cnt = 0;
      end else if (was_load && ValidD) begin
         load_cnt++;
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pcd", PCD, e);
            chk("sb_instr", InstrD, e);
            chk("sb_pcplus4", PCPlus4D, e + 32'd4);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0; FlushD = 1'b0;
      imem_req_ready = 1'b1;
      cyc(2);
      chk("rst_validd", 32'(ValidD), 32'd0);
      chk("rst_instrd", InstrD, 32'h13);
      chk("rst_pcd", PCD, 32'd0);
      chk("rst_pcplus4d", PCPlus4D, 32'd0);
      chk("rst_addr", imem_req_addr, 32'd0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rst_bubble", bubble_cnt, 32'd0);
      chk("rst_drop", drop_cnt, 32'd0);

      // streaming with 1-cycle memory
      load_exp(32'd0);
      rst = 1'b1;
      k = 0;
      while (!ValidD && k < 3) begin cyc(1); k++; end
      chk("warmup_valid", 32'(ValidD), 32'd1);
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         chk("steady_valid", 32'(ValidD), 32'd1);
      end
      chk("t1_bubble", bubble_cnt, PERF ? 32'd2 : 32'd0);

      // memory not ready after reset
      rst = 1'b0;
      cyc(2);
      imem_req_ready = 1'b0;
      load_exp(32'd0);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("noready_validd", 32'(ValidD), 32'd0);
         chk("noready_instrd", InstrD, 32'h13);
         chk("noready_pcf", imem_req_addr, 32'd0);
      end
      chk("noready_bubble", bubble_cnt, PERF ? 32'd10 : 32'd0);

      // stall fills the buffer, release resumes in order
      imem_req_ready = 1'b1;
      cyc(5);
      chk("prestall_loads", 32'(load_cnt), 32'd3);
      StallD = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         chk("stall_pcd", PCD, 32'h8);
         chk("stall_validd", 32'(ValidD), 32'd1);
         chk("credit_cap", 32'(acc_cnt - load_cnt <= 4), 32'd1);
      end
      chk("stall_inflight", 32'(acc_cnt - load_cnt), 32'd4);
      StallD = 1'b0;
      lc = load_cnt;
      cyc(6);
      chk("release_loads", 32'(load_cnt - lc), 32'd6);

      // redirect with two stale requests in a 3-cycle memory
      rst = 1'b0;
      lat = 3;
      cyc(2);
      load_exp(32'd0);
      rst = 1'b1;
      cyc(2);
      imem_req_ready = 1'b0;
      PCSrcE = 1'b1;
      PCTargetE = 32'h100;
      #1;
      chk("redirect_req_valid", 32'(imem_req_valid), 32'd0);
      cyc(1);
      PCSrcE = 1'b0;
      imem_req_ready = 1'b1;
      load_exp(32'h100);
      #1;
      chk("redirect_pcf", imem_req_addr, 32'h100);
      k = 0;
      while (!ValidD && k < 12) begin cyc(1); k++; end
      chk("redirect_valid", 32'(ValidD), 32'd1);
      chk("redirect_pcd", PCD, 32'h100);
      chk("redirect_drop", drop_cnt, PERF ? 32'd2 : 32'd0);

      // asynchronous reset mid-stream
      cyc(4);
      rst = 1'b0;
      #1;
      chk("midrst_validd", 32'(ValidD), 32'd0);
      chk("midrst_instrd", InstrD, 32'h13);
      chk("midrst_pcd", PCD, 32'd0);
      chk("midrst_pcplus4d", PCPlus4D, 32'd0);
      chk("midrst_pcf", imem_req_addr, 32'd0);
      chk("midrst_bubble", bubble_cnt, 32'd0);
      chk("midrst_drop", drop_cnt, 32'd0);
      cyc(2);
      lat = 1;
      load_exp(32'd0);
      rst = 1'b1;
      k = 0;
      while (!ValidD && k < 3) begin cyc(1); k++; end
      chk("restart_valid", 32'(ValidD), 32'd1);
      chk("restart_pcd", PCD, 32'd0);

      // flush wins over stall; buffered instructions follow without a gap
      cyc(3);
      StallD = 1'b1;
      FlushD = 1'b1;
      cyc(1);
      chk("flush_validd", 32'(ValidD), 32'd0);
      chk("flush_instrd", InstrD, 32'h13);
      chk("flush_pcd", PCD, 32'd0);
      chk("flush_pcplus4d", PCPlus4D, 32'd0);
      StallD = 1'b0;
      FlushD = 1'b0;
      lc = load_cnt;
      cyc(4);
      chk("postflush_loads", 32'(load_cnt - lc), 32'd4);
      chk("postflush_validd", 32'(ValidD), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
